// File: rtl/alu_op_sequencer_pkg.sv
// Shared definitions for the ALU op sequencer: command opcodes, ALU operation
// codes, FSM state encoding, ALU control bundle and default widths.
package alu_seq_pkg;

  localparam int DATA_W_DEF = 64;
  localparam int ADDR_W_DEF = 5;

  // Command opcodes; 5..7 are illegal
  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_SLT = 3'd4;

  // ALU operation select
  localparam logic [1:0] ALU_AND = 2'b00;
  localparam logic [1:0] ALU_OR  = 2'b01;
  localparam logic [1:0] ALU_SUM = 2'b10;
  localparam logic [1:0] ALU_SLT = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RDA  = 3'd1,
    ST_RDB  = 3'd2,
    ST_LATB = 3'd3,
    ST_EXEC = 3'd4,
    ST_WB   = 3'd5,
    ST_DONE = 3'd6
  } state_t;

  typedef struct packed {
    logic       a_invert;
    logic       b_invert;
    logic       carry_in;
    logic [1:0] operation;
  } alu_ctl_t;

  // Signed less-than from a subtraction: sign of the difference corrected by
  // overflow, so extreme operands still compare correctly.
  function automatic logic slt_less(input logic diff_msb, input logic overflow);
    return diff_msb ^ overflow;
  endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Bundle of the sequencer's command, regfile, ALU and result signals.
// master = the sequencer, slave = its environment (command source, regfile, ALU).
interface alu_op_sequencer_if
  import alu_seq_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
);
  // command port
  logic              cmd_valid;
  logic              cmd_ready;
  logic [2:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_rs;
  logic [ADDR_W-1:0] cmd_rt;
  logic [ADDR_W-1:0] cmd_rd;
  // regfile port
  logic [ADDR_W-1:0] rf_address;
  logic              rf_en_write;
  logic [DATA_W-1:0] rf_idata;
  logic [DATA_W-1:0] rf_data;
  // ALU port
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic              alu_a_invert;
  logic              alu_b_invert;
  logic              alu_carry_in;
  logic [1:0]        alu_operation;
  logic [DATA_W-1:0] alu_result;
  logic              alu_carry_out;
  logic              alu_overflow;
  // completion / result
  logic              done;
  logic              err;
  logic [DATA_W-1:0] res_value;
  logic              res_carry;
  logic              res_overflow;

  modport master (
    input  cmd_valid, cmd_op, cmd_rs, cmd_rt, cmd_rd,
    input  rf_data, alu_result, alu_carry_out, alu_overflow,
    output cmd_ready, rf_address, rf_en_write, rf_idata,
    output alu_a, alu_b, alu_a_invert, alu_b_invert, alu_carry_in, alu_operation,
    output done, err, res_value, res_carry, res_overflow
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_rs, cmd_rt, cmd_rd,
    output rf_data, alu_result, alu_carry_out, alu_overflow,
    input  cmd_ready, rf_address, rf_en_write, rf_idata,
    input  alu_a, alu_b, alu_a_invert, alu_b_invert, alu_carry_in, alu_operation,
    input  done, err, res_value, res_carry, res_overflow
  );

endinterface

// File: rtl/alu_op_sequencer_alu_ctl_decode.sv
// Pure combinational decode of a command opcode into ALU control lines plus
// an illegal-op flag. Illegal opcodes produce all-zero controls.
module alu_ctl_decode
  import alu_seq_pkg::*;
(
  input  logic [2:0] op,
  output alu_ctl_t   ctl,
  output logic       illegal
);

  // Opcode -> {a_invert, b_invert, carry_in, operation}
  always_comb begin
    ctl     = '0;
    illegal = 1'b0;
    case (op)
      OP_ADD: ctl.operation = ALU_SUM;
      OP_SUB: begin
        ctl.b_invert  = 1'b1;
        ctl.carry_in  = 1'b1;
        ctl.operation = ALU_SUM;
      end
      OP_AND: ctl.operation = ALU_AND;
      OP_OR:  ctl.operation = ALU_OR;
      OP_SLT: begin
        ctl.b_invert  = 1'b1;
        ctl.carry_in  = 1'b1;
        ctl.operation = ALU_SLT;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Multi-cycle controller running one register-to-register ALU command:
// read rs, read rt, execute on the external ALU, write back to rd.
// Fixed seven-state walk, so a held cmd_valid yields one command every 7 cycles.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int ZERO_REG = 1
)(
  input  logic                 clock,
  input  logic                 reset,
  alu_op_sequencer_if.master   bus
);

  state_t            state_reg;
  state_t            state_next;
  logic [2:0]        op_reg;
  logic [ADDR_W-1:0] rs_reg;
  logic [ADDR_W-1:0] rt_reg;
  logic [ADDR_W-1:0] rd_reg;
  logic [DATA_W-1:0] a_reg;
  logic [DATA_W-1:0] b_reg;
  logic [DATA_W-1:0] result_reg;
  logic              carry_reg;
  logic              ovf_reg;
  logic              done_reg;
  logic              err_reg;
  logic [DATA_W-1:0] res_value_reg;
  logic              res_carry_reg;
  logic              res_ovf_reg;

  alu_ctl_t          ctl;
  logic              illegal;
  logic              rs_is_zero;
  logic              rt_is_zero;
  logic              rd_is_zero;
  logic              write_ok;

  alu_ctl_decode u_decode (
    .op      (op_reg),
    .ctl     (ctl),
    .illegal (illegal)
  );

  assign rs_is_zero = (ZERO_REG != 0) && (rs_reg == '0);
  assign rt_is_zero = (ZERO_REG != 0) && (rt_reg == '0);
  assign rd_is_zero = (ZERO_REG != 0) && (rd_reg == '0);
  assign write_ok   = !illegal && !rd_is_zero;

  assign bus.alu_a        = a_reg;
  assign bus.alu_b        = b_reg;
  assign bus.done         = done_reg;
  assign bus.err          = err_reg;
  assign bus.res_value    = res_value_reg;
  assign bus.res_carry    = res_carry_reg;
  assign bus.res_overflow = res_ovf_reg;

  // State register; reset drops any in-flight command back to IDLE
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next state plus the state-decoded regfile, ALU-control and ready outputs
  always_comb begin
    state_next        = state_reg;
    bus.cmd_ready     = 1'b0;
    bus.rf_address    = '0;
    bus.rf_en_write   = 1'b0;
    bus.rf_idata      = '0;
    bus.alu_a_invert  = 1'b0;
    bus.alu_b_invert  = 1'b0;
    bus.alu_carry_in  = 1'b0;
    bus.alu_operation = 2'b00;
    case (state_reg)
      ST_IDLE: begin
        // ready is held low while reset is asserted so every output reads 0
        bus.cmd_ready = reset;
        if (bus.cmd_valid) state_next = ST_RDA;
      end
      ST_RDA: begin
        bus.rf_address = rs_reg;
        state_next     = ST_RDB;
      end
      ST_RDB: begin
        bus.rf_address = rt_reg;
        state_next     = ST_LATB;
      end
      ST_LATB, ST_EXEC: begin
        bus.alu_a_invert  = ctl.a_invert;
        bus.alu_b_invert  = ctl.b_invert;
        bus.alu_carry_in  = ctl.carry_in;
        bus.alu_operation = ctl.operation;
        state_next        = (state_reg == ST_LATB) ? ST_EXEC : ST_WB;
      end
      ST_WB: begin
        bus.rf_address  = rd_reg;
        bus.rf_en_write = write_ok;
        bus.rf_idata    = result_reg;
        state_next      = ST_DONE;
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Command latch, operand capture, ALU result capture and retire pulse
  always_ff @(posedge clock) begin
    if (!reset) begin
      op_reg        <= '0;
      rs_reg        <= '0;
      rt_reg        <= '0;
      rd_reg        <= '0;
      a_reg         <= '0;
      b_reg         <= '0;
      result_reg    <= '0;
      carry_reg     <= 1'b0;
      ovf_reg       <= 1'b0;
      done_reg      <= 1'b0;
      err_reg       <= 1'b0;
      res_value_reg <= '0;
      res_carry_reg <= 1'b0;
      res_ovf_reg   <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      err_reg  <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (bus.cmd_valid) begin
            op_reg <= bus.cmd_op;
            rs_reg <= bus.cmd_rs;
            rt_reg <= bus.cmd_rt;
            rd_reg <= bus.cmd_rd;
          end
        end
        // regfile data for rs arrives one cycle after the address
        ST_RDB:  a_reg <= rs_is_zero ? '0 : bus.rf_data;
        ST_LATB: b_reg <= rt_is_zero ? '0 : bus.rf_data;
        ST_EXEC: begin
          if (ctl.operation == ALU_SLT) begin
            result_reg <= {{(DATA_W-1){1'b0}},
                           slt_less(bus.alu_result[DATA_W-1], bus.alu_overflow)};
          end else begin
            result_reg <= bus.alu_result;
          end
          carry_reg <= bus.alu_carry_out;
          ovf_reg   <= bus.alu_overflow;
        end
        ST_WB: begin
          done_reg <= 1'b1;
          err_reg  <= illegal;
          if (!illegal) begin
            res_value_reg <= result_reg;
            res_carry_reg <= carry_reg;
            res_ovf_reg   <= ovf_reg;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer: a driver issues commands and pushes
// expected results computed from plain arithmetic; a monitor checks every
// regfile write, every done pulse and reset behaviour against that queue.
module tb_alu_op_sequencer;
  import alu_seq_pkg::*;

  localparam int DW = 64;
  localparam int AW = 5;

  typedef struct {
    int             accept_cyc;
    int             prev_accept;
    bit             gap_chk;
    bit             wr;
    bit             err;
    bit             chk_val;
    bit             chk_flags;
    bit             written;
    logic [2:0]     op;
    logic [AW-1:0]  rd;
    logic [DW-1:0]  value;
    bit             carry;
    bit             ovf;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  alu_op_sequencer_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  alu_op_sequencer #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int   cyc   = 0;
  logic rst_q = 1'b1;
  always @(posedge clock) begin
    cyc   <= cyc + 1;
    rst_q <= reset;
  end

  // Regfile device: registered read, synchronous write, bench preload port
  logic [DW-1:0] mem [32];
  logic          pre_en   = 1'b0;
  logic [AW-1:0] pre_addr = '0;
  logic [DW-1:0] pre_data = '0;
  always @(posedge clock) begin
    if (pre_en) mem[pre_addr] <= pre_data;
    else if (bus.rf_en_write) mem[bus.rf_address] <= bus.rf_idata;
    bus.rf_data <= mem[bus.rf_address];
  end

  // ALU device driven by the sequencer's control lines
  logic [DW-1:0] alu_aa, alu_bb;
  logic [DW:0]   alu_sum;
  always_comb begin
    alu_aa  = bus.alu_a_invert ? ~bus.alu_a : bus.alu_a;
    alu_bb  = bus.alu_b_invert ? ~bus.alu_b : bus.alu_b;
    alu_sum = {1'b0, alu_aa} + {1'b0, alu_bb} + {{DW{1'b0}}, bus.alu_carry_in};
    case (bus.alu_operation)
      2'b00:   bus.alu_result = alu_aa & alu_bb;
      2'b01:   bus.alu_result = alu_aa | alu_bb;
      default: bus.alu_result = alu_sum[DW-1:0];
    endcase
    bus.alu_carry_out = alu_sum[DW];
    bus.alu_overflow  = (alu_aa[DW-1] == alu_bb[DW-1]) && (alu_sum[DW-1] != alu_aa[DW-1]);
  end

  // Reference architectural state
  logic [DW-1:0] ref_regs [32];
  exp_t          q [$];
  bit            stim_done = 0;
  int            last_acc  = -100;
  bit            prev_hold = 0;
  int            total = 0;
  int            bad   = 0;
  logic [DW-1:0] specials [4];

  function automatic logic [DW-1:0] rref(input int idx);
    return (idx == 0) ? '0 : ref_regs[idx];
  endfunction

  function automatic exp_t model(input logic [2:0] op, input logic [DW-1:0] a,
                                 input logic [DW-1:0] b, input int rd);
    exp_t e;
    logic [DW:0] s;
    e.accept_cyc = 0; e.prev_accept = 0; e.gap_chk = 0; e.written = 0;
    e.op = op; e.rd = rd[AW-1:0]; e.value = '0; e.carry = 0; e.ovf = 0; e.err = 0;
    case (op)
      3'd0: begin
        s       = {1'b0, a} + {1'b0, b};
        e.value = s[DW-1:0];
        e.carry = s[DW];
        e.ovf   = (a[DW-1] == b[DW-1]) && (e.value[DW-1] != a[DW-1]);
      end
      3'd1, 3'd4: begin
        e.value = a - b;
        e.carry = (a >= b);
        e.ovf   = (a[DW-1] != b[DW-1]) && (e.value[DW-1] != a[DW-1]);
        if (op == 3'd4) e.value = ($signed(a) < $signed(b)) ? DW'(1) : DW'(0);
      end
      3'd2: e.value = a & b;
      3'd3: e.value = a | b;
      default: e.err = 1;
    endcase
    e.wr        = !e.err && (rd != 0);
    e.chk_val   = e.wr;
    e.chk_flags = e.wr && (op == 3'd0 || op == 3'd1 || op == 3'd4);
    return e;
  endfunction

  task automatic preload(input int idx, input logic [DW-1:0] val);
    pre_en   = 1'b1;
    pre_addr = idx[AW-1:0];
    pre_data = val;
    ref_regs[idx] = val;
    @(posedge clock); #1;
    pre_en = 1'b0;
  endtask

  task automatic issue(input logic [2:0] op, input int rs, input int rt, input int rd,
                       input bit hold, input bit push);
    exp_t e;
    bit   got;
    bus.cmd_op    = op;
    bus.cmd_rs    = rs[AW-1:0];
    bus.cmd_rt    = rt[AW-1:0];
    bus.cmd_rd    = rd[AW-1:0];
    bus.cmd_valid = 1'b1;
    got = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      if (bus.cmd_ready) begin got = 1; break; end
    end
    if (!got) begin
      $display("FAIL accept_timeout: cmd_ready=0 required 1 within 40 cycles");
      $fatal(1, "accept timeout");
    end
    e = model(op, rref(rs), rref(rt), rd);
    e.accept_cyc  = cyc;
    e.prev_accept = last_acc;
    e.gap_chk     = prev_hold;
    last_acc      = cyc;
    prev_hold     = hold;
    if (push) begin
      q.push_back(e);
      if (e.wr) ref_regs[rd] = e.value;
    end
    @(posedge clock); #1;
    if (!hold) bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 60; k++) begin
      @(negedge clock);
      if (q.size() == 0) break;
    end
    @(posedge clock); #1;
  endtask

  // Driver
  initial begin
    int op, rs, rt, rd, gap;
    bit hold;
    bus.cmd_valid = 1'b0;
    bus.cmd_op = '0; bus.cmd_rs = '0; bus.cmd_rt = '0; bus.cmd_rd = '0;
    specials[0] = 64'h8000_0000_0000_0000;
    specials[1] = 64'h7FFF_FFFF_FFFF_FFFF;
    specials[2] = 64'hFFFF_FFFF_FFFF_FFFF;
    specials[3] = 64'h0000_0000_0000_0001;
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    for (int i = 0; i < 32; i++) preload(i, {$urandom(), $urandom()});
    preload(0, 64'hDEAD_BEEF_0000_0001);

    preload(1, 64'd212);  preload(2, 64'd32);
    issue(3'd0, 1, 2, 11, 0, 1);  wait_idle();
    preload(9, 64'd4192); preload(10, 64'd190);
    issue(3'd1, 9, 10, 15, 0, 1); wait_idle();
    preload(7, 64'd632);  preload(8, 64'd4321);
    issue(3'd4, 7, 8, 14, 0, 1);  wait_idle();
    preload(7, 64'h8000_0000_0000_0000); preload(8, 64'd1);
    issue(3'd4, 7, 8, 14, 0, 1);  wait_idle();
    preload(5, 64'd185454903); preload(6, 64'd674545449);
    issue(3'd2, 5, 6, 16, 0, 1);
    issue(3'd3, 5, 6, 17, 0, 1);
    issue(3'd0, 5, 6, 0, 0, 1);
    issue(3'd0, 0, 6, 18, 0, 1);
    issue(3'd6, 1, 2, 19, 0, 1);
    issue(3'd0, 1, 2, 22, 1, 1);
    issue(3'd0, 22, 2, 23, 1, 1);
    issue(3'd0, 23, 1, 24, 0, 1);
    wait_idle();

    // abort a command in EXEC with reset; r20 must keep its old value
    preload(20, 64'h1234);
    issue(3'd0, 1, 2, 20, 0, 0);
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    issue(3'd0, 20, 0, 21, 0, 1);
    wait_idle();

    for (int n = 0; n < 40; n++) begin
      if (!prev_hold && ($urandom() % 4 == 0)) begin
        wait_idle();
        preload($urandom_range(1, 31), specials[$urandom() % 4]);
      end
      op   = $urandom() % 8;
      rs   = $urandom() % 32;
      rt   = $urandom() % 32;
      rd   = $urandom() % 32;
      hold = ($urandom() % 3 == 0) && (n != 39);
      issue(op[2:0], rs, rt, rd, hold, 1);
      if (!hold) begin
        gap = $urandom() % 3;
        if (gap != 0) begin
          repeat (gap) @(posedge clock);
          #1;
        end
      end
    end
    wait_idle();
    stim_done = 1;
  end

  task automatic chk(input bit ok, input string name, input string detail);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: %s", name, detail);
    end
  endtask

  // Monitor / scoreboard
  initial begin
    exp_t e;
    int   lat;
    while (!stim_done) begin
      @(negedge clock);
      if (!reset && !rst_q) begin
        chk(!bus.cmd_ready && !bus.rf_en_write && !bus.done && !bus.err &&
            !bus.res_carry && !bus.res_overflow && !bus.alu_a_invert &&
            !bus.alu_b_invert && !bus.alu_carry_in && bus.alu_operation == 2'b00 &&
            bus.rf_address == '0 && bus.rf_idata == '0 && bus.alu_a == '0 &&
            bus.alu_b == '0 && bus.res_value == '0,
            "reset_zero",
            $sformatf("got ready=%0b we=%0b done=%0b a=%h b=%h res=%h, all required 0",
                      bus.cmd_ready, bus.rf_en_write, bus.done, bus.alu_a, bus.alu_b,
                      bus.res_value));
      end else if (reset && rst_q) begin
        if (bus.err && !bus.done)
          chk(0, "err_alone", "got err=1 done=0, required err only with done");
        if (q.size() == 0) begin
          chk(!bus.rf_en_write && !bus.done, "idle_quiet",
              $sformatf("got we=%0b done=%0b addr=%0d, required both 0",
                        bus.rf_en_write, bus.done, bus.rf_address));
        end else begin
          lat = cyc - q[0].accept_cyc;
          if (lat >= 1 && lat <= 6)
            chk(!bus.cmd_ready, "busy_ready",
                $sformatf("got cmd_ready=%0b at cycle %0d of command, required 0",
                          bus.cmd_ready, lat));
          if (bus.rf_en_write) begin
            chk(q[0].wr && lat == 5 && bus.rf_address == q[0].rd && bus.rf_idata == q[0].value,
                "write",
                $sformatf("got addr=%0d data=%h lat=%0d, required wr=%0b addr=%0d data=%h lat=5",
                          bus.rf_address, bus.rf_idata, lat, q[0].wr, q[0].rd, q[0].value));
            q[0].written = 1;
          end
          if (bus.done) begin
            e = q.pop_front();
            $display("txn op=%0d rd=%0d lat=%0d err=%0b res=%h carry=%0b ovf=%0b",
                     e.op, e.rd, lat, bus.err, bus.res_value, bus.res_carry, bus.res_overflow);
            chk(lat == 6, "done_latency", $sformatf("got %0d, required 6", lat));
            chk(bus.err == e.err, "err", $sformatf("got %0b, required %0b", bus.err, e.err));
            chk(e.written == e.wr, "write_seen",
                $sformatf("got write=%0b, required %0b", e.written, e.wr));
            if (e.chk_val)
              chk(bus.res_value == e.value, "res_value",
                  $sformatf("got %h, required %h", bus.res_value, e.value));
            if (e.chk_flags)
              chk(bus.res_carry == e.carry && bus.res_overflow == e.ovf, "flags",
                  $sformatf("got c=%0b v=%0b, required c=%0b v=%0b",
                            bus.res_carry, bus.res_overflow, e.carry, e.ovf));
            if (e.gap_chk)
              chk(e.accept_cyc - e.prev_accept == 7, "b2b_spacing",
                  $sformatf("got %0d, required 7", e.accept_cyc - e.prev_accept));
          end else if (lat > 10) begin
            e = q.pop_front();
            chk(0, "done_timeout", $sformatf("got no done after %0d cycles, required 6", lat));
          end
        end
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running at time limit");
    $fatal(1, "watchdog");
  end

endmodule
